// File: rtl/slot_pkg.sv
// Shared definitions for the slot reel sequencer: state encoding and default reel geometry.
package slot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPIN3  = 3'd1,
        SPIN2  = 3'd2,
        SPIN1  = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam int DEF_NUM_SYMBOLS = 10;
    localparam int DEF_SYM_W       = 4;

endpackage

// File: rtl/slot_edge_det.sv
// Rising-edge detector for a level input: registers the level once and
// emits a one-cycle pulse the cycle after a sampled rise.
module slot_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic pulse
);

    logic lvl_p0;
    logic lvl_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_p0 <= 1'b0;
            lvl_p1 <= 1'b0;
        end else begin
            lvl_p0 <= lvl;
            lvl_p1 <= lvl_p0;
        end
    end

    assign pulse = lvl_p0 & ~lvl_p1;

endmodule

// File: rtl/slot_reel_sequencer.sv
// Three-reel slot sequencer: spin/stop FSM, reel advance, scoring and win blink.
// Optional automatic stop on the 1 Hz timebase is enabled by defining SLOT_AUTO_STOP_EN.
module slot_reel_sequencer
    import slot_pkg::*;
#(
    parameter int NUM_SYMBOLS     = DEF_NUM_SYMBOLS,
    parameter int SYM_W           = DEF_SYM_W,
    parameter int AUTO_STOP_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_fast,
    input  logic             tick_onehz,
    input  logic             tick_blink,
    input  logic             btn_spin,
    input  logic             btn_stop,
    output logic [SYM_W-1:0] reel0,
    output logic [SYM_W-1:0] reel1,
    output logic [SYM_W-1:0] reel2,
    output logic             busy,
    output logic             jackpot,
    output logic             pair,
    output logic             blink_on
);

    state_t           state;
    state_t           state_next;
    logic [SYM_W-1:0] reel_q [3];
    logic             fast_pulse;
    logic             onehz_pulse;
    logic             blink_pulse;
    logic             spin_pulse;
    logic             stop_pulse;
    logic             stop_eff;
    logic [2:0]       spinning;
    logic [2:0]       freezing;
    logic [2:0]       advance;
    logic             start_spin;
    logic             to_result;
    logic             score_jackpot;
    logic             score_pair;

    // Modular add with the sum kept one bit wider so the wrap compare cannot overflow.
    function automatic logic [SYM_W-1:0] wrap_add(input logic [SYM_W-1:0] sym,
                                                  input logic [SYM_W-1:0] inc);
        logic [SYM_W:0] sum;
        sum = {1'b0, sym} + {1'b0, inc};
        if (sum >= (SYM_W+1)'(NUM_SYMBOLS))
            sum = sum - (SYM_W+1)'(NUM_SYMBOLS);
        return sum[SYM_W-1:0];
    endfunction

    slot_edge_det u_ed_fast  (.clk(clk), .rst(rst), .lvl(tick_fast),  .pulse(fast_pulse));
    slot_edge_det u_ed_onehz (.clk(clk), .rst(rst), .lvl(tick_onehz), .pulse(onehz_pulse));
    slot_edge_det u_ed_blink (.clk(clk), .rst(rst), .lvl(tick_blink), .pulse(blink_pulse));
    slot_edge_det u_ed_spin  (.clk(clk), .rst(rst), .lvl(btn_spin),   .pulse(spin_pulse));
    slot_edge_det u_ed_stop  (.clk(clk), .rst(rst), .lvl(btn_stop),   .pulse(stop_pulse));

`ifdef SLOT_AUTO_STOP_EN
    localparam int CNT_W = $clog2(AUTO_STOP_TICKS + 1);

    logic [CNT_W-1:0] auto_cnt;
    logic             auto_stop;

    // The tick that would bring the count to AUTO_STOP_TICKS acts as the stop itself.
    assign auto_stop = onehz_pulse && (|spinning) && (auto_cnt == CNT_W'(AUTO_STOP_TICKS - 1));
    assign stop_eff  = stop_pulse | auto_stop;

    always_ff @(posedge clk) begin
        if (rst)
            auto_cnt <= '0;
        else if (state_next != state)
            auto_cnt <= '0;
        else if (onehz_pulse && (|spinning))
            auto_cnt <= auto_cnt + 1'b1;
    end
`else
    logic unused_onehz;

    assign unused_onehz = onehz_pulse & (AUTO_STOP_TICKS > 0);
    assign stop_eff     = stop_pulse;
`endif

    // Spinning mask and the reel a stop would freeze depend on state only.
    always_comb begin
        spinning = 3'b000;
        freezing = 3'b000;
        case (state)
            SPIN3:   begin spinning = 3'b111; freezing = 3'b001; end
            SPIN2:   begin spinning = 3'b110; freezing = 3'b010; end
            SPIN1:   begin spinning = 3'b100; freezing = 3'b100; end
            default: begin spinning = 3'b000; freezing = 3'b000; end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESULT: if (spin_pulse) state_next = SPIN3;
            SPIN3:        if (stop_eff)   state_next = SPIN2;
            SPIN2:        if (stop_eff)   state_next = SPIN1;
            SPIN1:        if (stop_eff)   state_next = RESULT;
            default:                      state_next = IDLE;
        endcase
    end

    assign start_spin = spin_pulse && ((state == IDLE) || (state == RESULT));
    assign to_result  = (state == SPIN1) && stop_eff;
    assign advance    = spinning & {3{fast_pulse}} & ~({3{stop_eff}} & freezing);

    assign score_jackpot = (reel_q[0] == reel_q[1]) && (reel_q[1] == reel_q[2]);
    assign score_pair    = !score_jackpot &&
                           ((reel_q[0] == reel_q[1]) || (reel_q[1] == reel_q[2]) ||
                            (reel_q[0] == reel_q[2]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            jackpot  <= 1'b0;
            pair     <= 1'b0;
            blink_on <= 1'b0;
            for (int i = 0; i < 3; i++)
                reel_q[i] <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == SPIN3) || (state_next == SPIN2) || (state_next == SPIN1);
            for (int i = 0; i < 3; i++)
                if (advance[i])
                    reel_q[i] <= wrap_add(reel_q[i], SYM_W'((i + 1) % NUM_SYMBOLS));
            if (start_spin) begin
                jackpot  <= 1'b0;
                pair     <= 1'b0;
                blink_on <= 1'b0;
            end else if (to_result) begin
                jackpot <= score_jackpot;
                pair    <= score_pair;
            end else if ((state == RESULT) && blink_pulse) begin
                blink_on <= (jackpot | pair) ? ~blink_on : 1'b0;
            end
        end
    end

    assign reel0 = reel_q[0];
    assign reel1 = reel_q[1];
    assign reel2 = reel_q[2];

endmodule

// File: tb/tb_slot_reel_sequencer.sv
// Scoreboard bench for slot_reel_sequencer: a reel-level model predicts each
// distinct output state; a monitor pops and compares whenever the outputs change.
module tb_slot_reel_sequencer;

    localparam int N = 10;
    localparam int W = 4;

    typedef logic [3*W+3:0] snap_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_fast, tick_onehz, tick_blink, btn_spin, btn_stop;
    logic [W-1:0] reel0, reel1, reel2;
    logic         busy, jackpot, pair, blink_on;

    always #5 clk = ~clk;

    slot_reel_sequencer #(
        .NUM_SYMBOLS(N),
        .SYM_W(W),
        .AUTO_STOP_TICKS(5)
    ) dut (
        .clk(clk), .rst(rst),
        .tick_fast(tick_fast), .tick_onehz(tick_onehz), .tick_blink(tick_blink),
        .btn_spin(btn_spin), .btn_stop(btn_stop),
        .reel0(reel0), .reel1(reel1), .reel2(reel2),
        .busy(busy), .jackpot(jackpot), .pair(pair), .blink_on(blink_on)
    );

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 0;
    bit    spin_hold = 0;

    // Reference model: reel values, how many reels still spin, score and LED.
    int    m_reel[3];
    int    m_nspin;
    bit    m_jp, m_pr, m_bl;
    int    m_cnt;
    snap_t m_last;

    function automatic snap_t model_snap();
        return {W'(m_reel[0]), W'(m_reel[1]), W'(m_reel[2]), (m_nspin > 0), m_jp, m_pr, m_bl};
    endfunction

    task automatic model_publish();
        snap_t s;
        s = model_snap();
        if (s != m_last) begin
            exp_q.push_back(s);
            m_last = s;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_reel[i] = 0;
        m_nspin = 0; m_jp = 0; m_pr = 0; m_bl = 0; m_cnt = 0;
        model_publish();
    endtask

    task automatic model_step(input bit spin, input bit stop, input bit fast,
                              input bit onehz, input bit blink);
        bit stop_eff;
        int first;
        if (m_nspin == 0) begin
            if (spin) begin
                m_nspin = 3; m_jp = 0; m_pr = 0; m_bl = 0; m_cnt = 0;
            end else if (blink && (m_jp || m_pr)) begin
                m_bl = !m_bl;
            end
        end else begin
            stop_eff = stop;
`ifdef SLOT_AUTO_STOP_EN
            if (onehz) begin
                m_cnt++;
                if (m_cnt == 5) stop_eff = 1;
            end
`endif
            first = 3 - m_nspin;
            if (fast)
                for (int i = first; i < 3; i++)
                    if (!(stop_eff && i == first))
                        m_reel[i] = (m_reel[i] + i + 1) % N;
            if (stop_eff) begin
                m_nspin--;
                m_cnt = 0;
                if (m_nspin == 0) begin
                    m_jp = (m_reel[0] == m_reel[1]) && (m_reel[1] == m_reel[2]);
                    m_pr = !m_jp && ((m_reel[0] == m_reel[1]) || (m_reel[1] == m_reel[2]) ||
                                     (m_reel[0] == m_reel[2]));
                end
            end
        end
        model_publish();
    endtask

    task automatic act(input bit spin, input bit stop, input bit fast,
                       input bit onehz, input bit blink);
        @(posedge clk); #1;
        btn_spin   = spin | spin_hold;
        btn_stop   = stop;
        tick_fast  = fast;
        tick_onehz = onehz;
        tick_blink = blink;
        model_step(spin && !spin_hold, stop, fast, onehz, blink);
        repeat (2) @(posedge clk); #1;
        btn_spin = spin_hold; btn_stop = 0; tick_fast = 0; tick_onehz = 0; tick_blink = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic hold_spin(input bit v);
        @(posedge clk); #1;
        if (v && !spin_hold) model_step(1, 0, 0, 0, 0);
        spin_hold = v;
        btn_spin  = v;
        repeat (5) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        btn_spin = 0; btn_stop = 0; tick_fast = 0; tick_onehz = 0; tick_blink = 0;
        spin_hold = 0;
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
    endtask

    // Monitor: every observed output change must match the next predicted state.
    initial begin
        snap_t prev, cur, e;
        wait (mon_en);
        @(negedge clk);
        prev = {reel0, reel1, reel2, busy, jackpot, pair, blink_on};
        forever begin
            @(negedge clk);
            cur = {reel0, reel1, reel2, busy, jackpot, pair, blink_on};
            if (cur !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_seq unexpected change actual=%h required=no_change", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL out_seq actual=%h required=%h", cur, e);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int r;
        rst = 1; btn_spin = 0; btn_stop = 0; tick_fast = 0; tick_onehz = 0; tick_blink = 0;
        for (int i = 0; i < 3; i++) m_reel[i] = 0;
        m_nspin = 0; m_jp = 0; m_pr = 0; m_bl = 0; m_cnt = 0; m_last = '0;
        repeat (3) @(posedge clk); #1;
        rst = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({reel0, reel1, reel2, busy, jackpot, pair, blink_on} !== snap_t'(0)) begin
            bad++;
            $display("FAIL reset_state actual=%h required=%h",
                     {reel0, reel1, reel2, busy, jackpot, pair, blink_on}, snap_t'(0));
        end
        mon_en = 1;
        repeat (2) @(posedge clk);

        // Spin, advance to 3,6,9 then wrap to 4,8,2; stop sequence ends on 4,0,5.
        act(1, 0, 0, 0, 0);
        repeat (4) act(0, 0, 1, 0, 0);
        act(0, 1, 0, 0, 0);
        act(0, 0, 1, 0, 0);
        act(0, 1, 0, 0, 0);
        act(0, 1, 0, 0, 0);
        repeat (4) act(0, 0, 0, 0, 1);

        // Ten advances bring every reel back to 0: jackpot and a blinking LED.
        do_reset();
        act(1, 0, 0, 0, 0);
        repeat (10) act(0, 0, 1, 0, 0);
        repeat (3) act(0, 1, 0, 0, 0);
        repeat (3) act(0, 0, 0, 0, 1);

        // Stop and fast together, then a held spin button across the whole spin.
        do_reset();
        act(1, 0, 0, 0, 0);
        repeat (3) act(0, 0, 1, 0, 0);
        act(0, 1, 1, 0, 0);
        hold_spin(1);
        act(0, 0, 1, 0, 0);
        act(0, 1, 0, 0, 0);
        act(0, 1, 0, 0, 0);
        act(0, 0, 0, 0, 1);
        repeat (4) @(posedge clk);
        hold_spin(0);

        // Reset in the middle of SPIN2, then held spin only counts once.
        act(1, 0, 0, 0, 0);
        act(0, 0, 1, 0, 0);
        act(0, 1, 0, 0, 0);
        do_reset();
        repeat (6) @(posedge clk);
        hold_spin(1);
        act(0, 0, 1, 0, 0);
        repeat (3) act(0, 1, 0, 0, 0);
        repeat (6) @(posedge clk);
        hold_spin(0);
        hold_spin(1);
        act(0, 0, 1, 0, 0);
        hold_spin(0);
        repeat (3) act(0, 1, 0, 0, 0);

        // One-hertz timebase: auto stops when enabled, no effect otherwise.
        do_reset();
        act(1, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            act(0, 0, 0, 1, 0);
            if (k % 5 == 0) act(0, 0, 1, 0, 0);
        end
        repeat (3) act(0, 1, 0, 0, 0);

        // Randomized mix of simultaneous inputs with occasional resets.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 2)
                do_reset();
            else
                act($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 20);
        end

        repeat (10) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL out_drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
